// File: rtl/cci_mpf_prim_repl_lru_client_pkg.sv
// cci_mpf_prim_repl_lru_client_pkg: shared LRU client types, victim FSM states and way-to-one-hot helper
package cci_mpf_prim_repl_lru_client_pkg;
  localparam int DEF_N_WAYS = 4;
  localparam int DEF_N_ENTRIES = 1024;
  localparam int MAX_WAYS = 64;
  typedef logic [$clog2(DEF_N_ENTRIES)-1:0] t_repl_entry_idx;
  typedef logic [DEF_N_WAYS-1:0] t_repl_way_vec;
  typedef logic [$clog2(DEF_N_WAYS)-1:0] t_repl_way_idx;
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RSP} t_victim_state;
  function automatic logic [MAX_WAYS-1:0] way_to_vec(input int unsigned way);
    return MAX_WAYS'(1) << way;
  endfunction
endpackage

// File: rtl/cci_mpf_prim_repl_ref_fifo.sv
// cci_mpf_prim_repl_ref_fifo: coalescing hit-reference FIFO (hit_* in, ref_* registered out to LRU port 0, dropped count)
module cci_mpf_prim_repl_ref_fifo
  import cci_mpf_prim_repl_lru_client_pkg::*;
#(
  parameter int N_WAYS = DEF_N_WAYS,
  parameter int N_ENTRIES = DEF_N_ENTRIES,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(N_ENTRIES)-1:0] hit_idx,
  input  logic [$clog2(N_WAYS)-1:0]    hit_way,
  input  logic                         hit_en,
  input  logic                         lru_rdy,
  output logic [$clog2(N_ENTRIES)-1:0] ref_idx,
  output logic [N_WAYS-1:0]            ref_vec,
  output logic                         ref_en,
  output logic [15:0]                  dropped
);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [IW-1:0]     idx;
    logic [N_WAYS-1:0] vec;
  } t_ent;
  t_ent mem_q [DEPTH];
  t_ent mem_d [DEPTH];
  t_ent ref_q, ref_d;
  logic ref_en_q, ref_en_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, tail;
  logic [PW:0] cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d;
  logic [N_WAYS-1:0] hit_vec;
  logic pop, tail_hit, push, drop;
  assign hit_vec = N_WAYS'(way_to_vec(32'(hit_way)));
  assign tail = wr_q - 1'b1;
  always_comb begin
    pop = lru_rdy && cnt_q != '0;
    tail_hit = hit_en && cnt_q != '0 && mem_q[tail].idx == hit_idx && !(pop && cnt_q == (PW+1)'(1));
    push = hit_en && !tail_hit && (cnt_q != (PW+1)'(DEPTH) || pop);
    drop = hit_en && !tail_hit && !push;
    mem_d = mem_q;
    if (tail_hit) mem_d[tail].vec = mem_q[tail].vec | hit_vec;
    if (push) mem_d[wr_q] = '{idx: hit_idx, vec: hit_vec};
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    drop_d = drop_q + 16'(drop && drop_q != '1);
    ref_en_d = pop;
    ref_d = pop ? mem_q[rd_q] : ref_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      ref_q <= '0;
      ref_en_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
    end else begin
      mem_q <= mem_d;
      ref_q <= ref_d;
      ref_en_q <= ref_en_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
  assign ref_idx = ref_q.idx;
  assign ref_vec = ref_q.vec;
  assign ref_en = ref_en_q;
  assign dropped = drop_q;
endmodule

// File: rtl/cci_mpf_prim_repl_lru_client.sv
// cci_mpf_prim_repl_lru_client: victim request/response FSM over one LRU lookup plus coalesced hit references to LRU port 0
module cci_mpf_prim_repl_lru_client
  import cci_mpf_prim_repl_lru_client_pkg::*;
#(
  parameter int N_WAYS = DEF_N_WAYS,
  parameter int N_ENTRIES = DEF_N_ENTRIES,
  parameter int HIT_FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(N_ENTRIES)-1:0] victimReqIdx,
  input  logic                         victimReqEn,
  output logic                         victimReqRdy,
  output logic [$clog2(N_WAYS)-1:0]    victimRspWay,
  output logic [N_WAYS-1:0]            victimRspWayVec,
  output logic                         victimRspValid,
  input  logic                         victimRspRdy,
  input  logic [$clog2(N_ENTRIES)-1:0] hitIdx,
  input  logic [$clog2(N_WAYS)-1:0]    hitWay,
  input  logic                         hitEn,
  output logic [15:0]                  droppedHits,
  input  logic                         lruRdy,
  output logic [$clog2(N_ENTRIES)-1:0] lruLookupIdx,
  output logic                         lruLookupEn,
  input  logic [$clog2(N_WAYS)-1:0]    lruLookupRsp,
  input  logic [N_WAYS-1:0]            lruLookupVecRsp,
  input  logic                         lruLookupRspRdy,
  output logic [$clog2(N_ENTRIES)-1:0] lruRefIdx0,
  output logic [N_WAYS-1:0]            lruRefWayVec0,
  output logic                         lruRefEn0,
  output logic [$clog2(N_ENTRIES)-1:0] lruRefIdx1,
  output logic [N_WAYS-1:0]            lruRefWayVec1,
  output logic                         lruRefEn1
);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int WW = $clog2(N_WAYS);
  t_victim_state state_q, state_d;
  logic req_rdy_q, req_rdy_d, lookup_en_q, lookup_en_d, rsp_valid_q, rsp_valid_d, ref1_en_q, ref1_en_d;
  logic [IW-1:0] lookup_idx_q, lookup_idx_d, ref1_idx_q, ref1_idx_d;
  logic [WW-1:0] way_q, way_d;
  logic [N_WAYS-1:0] vec_q, vec_d, ref1_vec_q, ref1_vec_d;
  always_comb begin
    state_d = state_q;
    req_rdy_d = 1'b0;
    lookup_en_d = 1'b0;
    lookup_idx_d = lookup_idx_q;
    way_d = way_q;
    vec_d = vec_q;
    rsp_valid_d = rsp_valid_q;
    ref1_en_d = 1'b0;
    ref1_idx_d = ref1_idx_q;
    ref1_vec_d = ref1_vec_q;
    case (state_q)
      S_IDLE: begin
        if (victimReqEn && req_rdy_q) begin
          state_d = S_LOOKUP;
          lookup_en_d = 1'b1;
          lookup_idx_d = victimReqIdx;
        end else req_rdy_d = lruRdy;
      end
      S_LOOKUP: state_d = S_WAIT;
      S_WAIT: begin
        if (lruLookupRspRdy) begin
          state_d = S_RSP;
          way_d = lruLookupRsp;
          vec_d = lruLookupVecRsp;
          rsp_valid_d = 1'b1;
        end
      end
      S_RSP: begin
        if (victimRspRdy) begin
          state_d = S_IDLE;
          rsp_valid_d = 1'b0;
          ref1_en_d = 1'b1;
          ref1_idx_d = lookup_idx_q;
          ref1_vec_d = N_WAYS'(way_to_vec(32'(way_q)));
          req_rdy_d = lruRdy;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_rdy_q <= 1'b0;
      lookup_en_q <= 1'b0;
      lookup_idx_q <= '0;
      way_q <= '0;
      vec_q <= '0;
      rsp_valid_q <= 1'b0;
      ref1_en_q <= 1'b0;
      ref1_idx_q <= '0;
      ref1_vec_q <= '0;
    end else begin
      state_q <= state_d;
      req_rdy_q <= req_rdy_d;
      lookup_en_q <= lookup_en_d;
      lookup_idx_q <= lookup_idx_d;
      way_q <= way_d;
      vec_q <= vec_d;
      rsp_valid_q <= rsp_valid_d;
      ref1_en_q <= ref1_en_d;
      ref1_idx_q <= ref1_idx_d;
      ref1_vec_q <= ref1_vec_d;
    end
  end
  assign victimReqRdy = req_rdy_q;
  assign victimRspWay = way_q;
  assign victimRspWayVec = vec_q;
  assign victimRspValid = rsp_valid_q;
  assign lruLookupIdx = lookup_idx_q;
  assign lruLookupEn = lookup_en_q;
  assign lruRefIdx1 = ref1_idx_q;
  assign lruRefWayVec1 = ref1_vec_q;
  assign lruRefEn1 = ref1_en_q;
  cci_mpf_prim_repl_ref_fifo #(
    .N_WAYS(N_WAYS),
    .N_ENTRIES(N_ENTRIES),
    .DEPTH(HIT_FIFO_DEPTH)
  ) u_ref_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .hit_idx(hitIdx),
    .hit_way(hitWay),
    .hit_en(hitEn),
    .lru_rdy(lruRdy),
    .ref_idx(lruRefIdx0),
    .ref_vec(lruRefWayVec0),
    .ref_en(lruRefEn0),
    .dropped(droppedHits)
  );
endmodule

// File: tb/tb_cci_mpf_prim_repl_lru_client.sv
// tb_cci_mpf_prim_repl_lru_client: scoreboard bench for victim FSM and coalescing hit-reference path
module tb_cci_mpf_prim_repl_lru_client;
  logic clk = 1'b0;
  logic reset_n;
  logic [9:0] victimReqIdx, hitIdx, lruLookupIdx, lruRefIdx0, lruRefIdx1;
  logic victimReqEn, victimReqRdy, victimRspValid, victimRspRdy, hitEn, lruRdy, lruLookupEn, lruLookupRspRdy, lruRefEn0, lruRefEn1;
  logic [1:0] victimRspWay, hitWay, lruLookupRsp;
  logic [3:0] victimRspWayVec, lruLookupVecRsp, lruRefWayVec0, lruRefWayVec1;
  logic [15:0] droppedHits;
  logic any_out;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_lookup[$], exp_rsp[$], exp_ref1[$], exp_ref0[$];
  logic [9:0] lru_q[$];

  always #5 clk = ~clk;

  cci_mpf_prim_repl_lru_client #(.N_WAYS(4), .N_ENTRIES(1024), .HIT_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .victimReqIdx(victimReqIdx), .victimReqEn(victimReqEn), .victimReqRdy(victimReqRdy),
    .victimRspWay(victimRspWay), .victimRspWayVec(victimRspWayVec), .victimRspValid(victimRspValid), .victimRspRdy(victimRspRdy),
    .hitIdx(hitIdx), .hitWay(hitWay), .hitEn(hitEn), .droppedHits(droppedHits),
    .lruRdy(lruRdy), .lruLookupIdx(lruLookupIdx), .lruLookupEn(lruLookupEn),
    .lruLookupRsp(lruLookupRsp), .lruLookupVecRsp(lruLookupVecRsp), .lruLookupRspRdy(lruLookupRspRdy),
    .lruRefIdx0(lruRefIdx0), .lruRefWayVec0(lruRefWayVec0), .lruRefEn0(lruRefEn0),
    .lruRefIdx1(lruRefIdx1), .lruRefWayVec1(lruRefWayVec1), .lruRefEn1(lruRefEn1)
  );

  assign any_out = |{victimReqRdy, victimRspWay, victimRspWayVec, victimRspValid, droppedHits, lruLookupIdx, lruLookupEn,
                     lruRefIdx0, lruRefWayVec0, lruRefEn0, lruRefIdx1, lruRefWayVec1, lruRefEn1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // Scoreboard monitor: every output event pops and compares its expected value
  always @(negedge clk) begin
    if (lruLookupEn) begin
      if (exp_lookup.size() == 0) unexpected("lookup");
      else chk("lookup_idx", 64'(lruLookupIdx), 64'(exp_lookup.pop_front()));
    end
    if (victimRspValid && victimRspRdy) begin
      if (exp_rsp.size() == 0) unexpected("victim_rsp");
      else chk("victim_rsp", 64'({victimRspWay, victimRspWayVec}), 64'(exp_rsp.pop_front()));
    end
    if (lruRefEn1) begin
      if (exp_ref1.size() == 0) unexpected("ref1");
      else chk("ref1", 64'({lruRefIdx1, lruRefWayVec1}), 64'(exp_ref1.pop_front()));
    end
    if (lruRefEn0) begin
      if (exp_ref0.size() == 0) unexpected("ref0");
      else chk("ref0", 64'({lruRefIdx0, lruRefWayVec0}), 64'(exp_ref0.pop_front()));
    end
  end

  // LRU model: answers each lookup after {lat} cycles with {way}; lat 0 means never answer
  initial begin
    logic [9:0] e;
    lruLookupRspRdy = 1'b0;
    lruLookupRsp = '0;
    lruLookupVecRsp = '0;
    forever begin
      @(negedge clk);
      if (lruLookupEn && lru_q.size() != 0) begin
        e = lru_q.pop_front();
        if (e[9:2] != 0) begin
          repeat (int'(e[9:2])) @(posedge clk);
          #1;
          lruLookupRspRdy = 1'b1;
          lruLookupRsp = e[1:0];
          lruLookupVecRsp = 4'b1 << e[1:0];
          @(posedge clk);
          #1 lruLookupRspRdy = 1'b0;
        end
      end
    end
  end

  task automatic req(input logic [9:0] idx, input logic [1:0] way, input int lat);
    bit ok = 0;
    exp_lookup.push_back(32'(idx));
    lru_q.push_back({8'(lat), way});
    if (lat != 0) begin
      exp_rsp.push_back(32'({way, 4'b1 << way}));
      exp_ref1.push_back(32'({idx, 4'b1 << way}));
    end
    victimReqIdx = idx;
    victimReqEn = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = victimReqRdy;
    end
    if (!ok) unexpected("req_rdy_timeout");
    @(posedge clk);
    #1 victimReqEn = 1'b0;
  endtask

  task automatic accept();
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = victimRspValid;
    end
    if (!ok) unexpected("rsp_valid_timeout");
    @(posedge clk);
    #1 victimRspRdy = 1'b1;
    @(posedge clk);
    #1 victimRspRdy = 1'b0;
  endtask

  task automatic hit(input logic [9:0] idx, input logic [1:0] way);
    hitIdx = idx;
    hitWay = way;
    hitEn = 1'b1;
    @(posedge clk);
    #1 hitEn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    victimReqIdx = '0;
    victimReqEn = 1'b0;
    victimRspRdy = 1'b0;
    hitIdx = '0;
    hitWay = '0;
    hitEn = 1'b0;
    lruRdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(any_out), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("req_rdy_after_reset", 64'(victimReqRdy), 64'(1));
    @(posedge clk);
    #1;
    // Basic victim transaction with a held-off consumer
    req(10'h02A, 2'd2, 3);
    @(negedge clk);
    chk("lookup_en_t1", 64'(lruLookupEn), 64'(1));
    repeat (3) @(negedge clk);
    chk("rsp_valid_t4", 64'(victimRspValid), 64'(0));
    @(negedge clk);
    chk("rsp_t5", 64'({victimRspValid, victimRspWay, victimRspWayVec}), 64'({1'b1, 2'd2, 4'b0100}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rsp_hold", 64'({victimRspValid, victimReqRdy, victimRspWay, victimRspWayVec}), 64'({1'b1, 1'b0, 2'd2, 4'b0100}));
    end
    accept();
    @(negedge clk);
    chk("ref1_en_and_req_rdy_r1", 64'({lruRefEn1, victimReqRdy}), 64'(2'b11));
    @(negedge clk);
    chk("ref1_single_cycle", 64'(lruRefEn1), 64'(0));
    // Coalescing two hits to the same index
    @(posedge clk);
    #1 lruRdy = 1'b0;
    hit(10'd5, 2'd1);
    hit(10'd5, 2'd3);
    exp_ref0.push_back(32'({10'd5, 4'b1010}));
    repeat (3) @(posedge clk);
    #1 lruRdy = 1'b1;
    repeat (5) @(posedge clk);
    #1 lruRdy = 1'b0;
    // Overflow: 6 distinct hits into a 4-deep buffer
    for (int i = 0; i < 6; i++) begin
      hit(10'(10 + i), 2'(i));
      if (i < 4) exp_ref0.push_back(32'({10'(10 + i), 4'b1 << 2'(i)}));
    end
    @(negedge clk);
    chk("dropped_hits", 64'(droppedHits), 64'(2));
    @(posedge clk);
    #1 lruRdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    // Same index while the single entry is being popped must not coalesce
    hit(10'd7, 2'd0);
    hit(10'd7, 2'd1);
    exp_ref0.push_back(32'({10'd7, 4'b0001}));
    exp_ref0.push_back(32'({10'd7, 4'b0010}));
    @(negedge clk);
    chk("ref0_latency_t2", 64'(lruRefEn0), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    // Reset while in WAIT with the hit buffer holding entries
    req(10'h0FF, 2'd0, 0);
    lruRdy = 1'b0;
    hit(10'h033, 2'd0);
    hit(10'h034, 2'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 chk("async_reset_outputs", 64'(any_out), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    lruRdy = 1'b1;
    repeat (4) @(negedge clk);
    chk("dropped_after_reset", 64'(droppedHits), 64'(0));
    @(posedge clk);
    #1;
    req(10'h155, 2'd1, 4);
    accept();
    // Concurrent victim traffic with random latency and a hit stream
    fork
      begin
        logic [1:0] ways [3] = '{2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 3; k++) begin
          req(10'(10'h200 + k), ways[k], int'($urandom_range(8, 3)));
          accept();
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          exp_ref0.push_back(32'({10'(10'h100 + i), 4'b1 << 2'(i)}));
          hit(10'(10'h100 + i), 2'(i));
        end
      end
    join
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("lookups_left", 64'(exp_lookup.size()), 64'(0));
    chk("rsps_left", 64'(exp_rsp.size()), 64'(0));
    chk("ref1_left", 64'(exp_ref1.size()), 64'(0));
    chk("ref0_left", 64'(exp_ref0.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cci_mpf_prim_repl_lru_client.md
# cci_mpf_prim_repl_lru_client

Requester-side front end for the pseudo-LRU replacement primitive. It serves cache fill logic with a victim-way request/response handshake. It turns each request into a single LRU lookup, returns the chosen way, and marks that way referenced. It also buffers and coalesces cache-hit references into the LRU's reference port 0. It sits between a set-associative tag pipeline and the LRU table, one instance per cache.

## Interface
- N_WAYS, 4, associativity; power of 2, at least 2
- N_ENTRIES, 1024, sets per way; index width is $clog2(N_ENTRIES)
- HIT_FIFO_DEPTH, 4, hit-reference buffer depth; power of 2, at least 2

Ports (clock and reset first):
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- victimReqIdx  in  IDX  set index for a fill
- victimReqEn  in  1  request valid
- victimReqRdy  out  1  request accepted when both victimReqEn and victimReqRdy are high
- victimRspWay  out  $clog2(N_WAYS)  chosen way, as an index
- victimRspWayVec  out  N_WAYS  chosen way, one-hot
- victimRspValid  out  1  response valid
- victimRspRdy  in  1  consumer accepts the response
- hitIdx  in  IDX  set index of a hit
- hitWay  in  $clog2(N_WAYS)  way that hit
- hitEn  in  1  hit event; no backpressure
- droppedHits  out  16  saturating count of hits dropped because the buffer was full
- lruRdy  in  1  LRU initialised
- lruLookupIdx / lruLookupEn  out  IDX / 1  LRU lookup request
- lruLookupRsp / lruLookupVecRsp / lruLookupRspRdy  in  $clog2(N_WAYS) / N_WAYS / 1  LRU lookup response
- lruRefIdx0 / lruRefWayVec0 / lruRefEn0  out  IDX / N_WAYS / 1  hit references
- lruRefIdx1 / lruRefWayVec1 / lruRefEn1  out  IDX / N_WAYS / 1  victim-marking references

## Operation
- Every output is registered.
- While reset_n is low, every output is 0, the FSM is in IDLE, the FIFO is empty and droppedHits is 0.
- Victim FSM states are IDLE, LOOKUP, WAIT and RSP.
- IDLE: victimReqRdy = lruRdy. On handshake, latch the index and go to LOOKUP.
- LOOKUP: lruLookupEn is high for exactly one cycle, with lruLookupIdx set to the latched index. Then go to WAIT.
- WAIT: hold until lruLookupRspRdy. Capture lruLookupRsp and lruLookupVecRsp, then go to RSP. The block makes no assumption about lookup latency. A lruLookupRspRdy pulse outside WAIT is ignored.
- RSP: victimRspValid is high and the response is held stable until victimRspRdy. On acceptance, issue lruRefEn1 for one cycle with the latched index and one-hot way, then return to IDLE.
- lruRdy falling mid-transaction does not abort the transaction.
- Hit FIFO, enqueue: on hitEn, store {hitIdx, one-hot(hitWay)}.
- Hit FIFO, coalesce: if the FIFO is non-empty, the tail index equals hitIdx and the tail is not being popped this cycle, OR the way vector into the tail instead of enqueueing.
- Hit FIFO, full: a non-coalescing hit is dropped, unless a pop happens in the same cycle. droppedHits increments by 1 and saturates at 0xFFFF.
- Hit FIFO, drain: when lruRdy is high and the FIFO is non-empty, pop the head into the lruRef*0 registers. Otherwise lruRefEn0 is 0.
- Hits are never OR'd into the victim path or into an entry already popped.

## Timing
- Request handshake at cycle t: lruLookupEn is high in t+1.
- With the 3-cycle LRU, lruLookupRspRdy is high in t+4 and victimRspValid is high from t+5.
- Response accepted in cycle r: lruRefEn1 is high in r+1, and victimReqRdy is high again in r+1.
- Minimum request-to-request spacing with the 3-cycle LRU is 6 cycles.
- Hit at cycle t into an empty FIFO with lruRdy high: lruRefEn0 is high in t+2. Sustained drain rate is one entry per cycle.

## Structure
- Shared package: t_repl_entry_idx, t_repl_way_vec, t_repl_way_idx, and a function that converts a way index to a one-hot vector.
- Sub-module cci_mpf_prim_repl_ref_fifo: a coalescing FIFO with tail-compare logic and a drop counter.
- The victim FSM lives in the top module.

## Test plan
- Reset, then lruRdy=1; request index 0x2A; the LRU returns way 2 in t+4. Required: lruLookupIdx=0x2A in t+1; victimRspWay=2 and victimRspWayVec=4'b0100 from t+5; after acceptance, lruRefEn1 with idx 0x2A and vec 4'b0100 for exactly one cycle.
- Hold victimRspRdy low for 10 cycles. Required: the response stays stable, victimReqRdy=0, and no second lruLookupEn.
- Send hits (5, way 1) and (5, way 3) on consecutive cycles while lruRdy=0. Required: one entry with vec 4'b1010; after lruRdy rises, a single lruRefEn0 pulse.
- Send 6 distinct-index hits while lruRdy=0 with depth 4. Required: droppedHits=2; after lruRdy rises, 4 references drain in order.
- Pulse reset_n low during WAIT and with the FIFO non-empty. Required: all outputs 0 immediately, FIFO empty, and a new request is accepted after release.
- Issue a lookup response with a randomized 3–8 cycle delay, while hits stream concurrently. Required: the victim and ref0 paths do not interfere.
